// File: rtl/riscv_core_dcache_axi_read_adapter.sv
// D-cache refill engine: turns a miss request into one aligned AXI4 INCR read burst
// and assembles the returned beats into a full cache block for the replace path.
module riscv_core_dcache_axi_read_adapter #(
  parameter int                  ADDR_WIDTH    = 64,
  parameter int                  AXI_BUS_WIDTH = 64,
  parameter int                  BLOCK_WIDTH   = 256,
  parameter int                  ID_WIDTH      = 4,
  parameter logic [ID_WIDTH-1:0] ID_VALUE      = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]    i_mem_read_address,
  output logic                     o_mem_read_done,
  output logic [BLOCK_WIDTH-1:0]   o_block_to_cache,
  output logic                     o_bus_error,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  output logic [ADDR_WIDTH-1:0]    o_araddr,
  output logic [7:0]               o_arlen,
  output logic [2:0]               o_arsize,
  output logic [1:0]               o_arburst,
  output logic [ID_WIDTH-1:0]      o_arid,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [AXI_BUS_WIDTH-1:0] i_rdata,
  input  logic [1:0]               i_rresp,
  input  logic                     i_rlast,
  input  logic [ID_WIDTH-1:0]      i_rid
);

  localparam int BEATS = BLOCK_WIDTH / AXI_BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_arvalid, w_arvalid_nxt;
  logic                     r_rready, w_rready_nxt;
  logic [ADDR_WIDTH-1:0]    r_araddr, w_araddr_nxt;
  logic [BLOCK_WIDTH-1:0]   r_block, w_block_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic                     r_err, w_err_nxt;
  logic                     r_armed, w_armed_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_bus_err, w_bus_err_nxt;
  logic                     w_beat, w_last_beat, w_beat_err;
  logic                     w_unused_offset;

  // Byte offset within the block never reaches the bus: bursts are block aligned.
  assign w_unused_offset = &{1'b0, i_mem_read_address[OFF_W-1:0]};

  assign w_beat      = (r_state == S_DATA) & i_rvalid & r_rready;
  assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
  // rlast must coincide exactly with the final beat; anything else marks the burst faulty.
  assign w_beat_err  = i_rresp[1] | (i_rid != ID_VALUE) | (i_rlast != w_last_beat);

  always_comb begin
    w_state_nxt   = r_state;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_araddr_nxt  = r_araddr;
    w_block_nxt   = r_block;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err;
    w_armed_nxt   = r_armed | ~i_mem_read_req;
    w_done_nxt    = 1'b0;
    w_bus_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mem_read_req && r_armed) begin
          w_araddr_nxt  = {i_mem_read_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          w_arvalid_nxt = 1'b1;
          w_state_nxt   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_beat) begin
          w_block_nxt[int'(r_cnt)*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] = i_rdata;
          w_cnt_nxt = r_cnt + 1'b1;
          w_err_nxt = r_err | w_beat_err;
          if (w_last_beat) begin
            w_rready_nxt  = 1'b0;
            w_done_nxt    = 1'b1;
            w_bus_err_nxt = r_err | w_beat_err;
            w_state_nxt   = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Controller may still hold req this cycle; a low sample is needed to re-arm.
        w_err_nxt   = 1'b0;
        w_armed_nxt = ~i_mem_read_req;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_araddr  <= '0;
      r_block   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_armed   <= 1'b1;
      r_done    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_araddr  <= w_araddr_nxt;
      r_block   <= w_block_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
      r_armed   <= w_armed_nxt;
      r_done    <= w_done_nxt;
      r_bus_err <= w_bus_err_nxt;
    end
  end

  assign o_mem_read_done  = r_done;
  assign o_bus_error      = r_bus_err;
  assign o_block_to_cache = r_block;
  assign o_arvalid        = r_arvalid;
  assign o_araddr         = r_araddr;
  assign o_rready         = r_rready;
  assign o_arlen          = 8'(BEATS - 1);
  assign o_arsize         = 3'd3;
  assign o_arburst        = 2'b01;
  assign o_arid           = ID_VALUE;

endmodule
